// File: rtl/alu_mdu.sv
// alu_mdu: EX-stage ALU with single-cycle logic/arithmetic ops plus an
// iterative radix-2 multiply/divide unit that writes the HI/LO registers.
//
// Handshake: a mul/div op is launched by holding start high with a mul/div
// ctl value across one rising edge while busy is low. busy stays high from
// that edge until HI/LO are written. done is high for exactly the one cycle
// after HI/LO change. Starts seen while busy are dropped, and flush beats start
// on the same edge.
module alu_mdu #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       ctl,
  input  logic [WIDTH-1:0] data_1,
  input  logic [WIDTH-1:0] data_2,
  input  logic             start,
  input  logic             flush,
  output logic [WIDTH-1:0] res,
  output logic             zero,
  output logic             ovf,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       dbg_state
);

  localparam logic [3:0] CTL_AND   = 4'b0000;
  localparam logic [3:0] CTL_OR    = 4'b0001;
  localparam logic [3:0] CTL_ADD   = 4'b0010;
  localparam logic [3:0] CTL_XOR   = 4'b0011;
  localparam logic [3:0] CTL_NOR   = 4'b0100;
  localparam logic [3:0] CTL_SUB   = 4'b0110;
  localparam logic [3:0] CTL_SLT   = 4'b0111;
  localparam logic [3:0] CTL_MFHI  = 4'b1000;
  localparam logic [3:0] CTL_MFLO  = 4'b1001;
  localparam logic [3:0] CTL_MULT  = 4'b1010;
  localparam logic [3:0] CTL_MULTU = 4'b1011;
  localparam logic [3:0] CTL_DIV   = 4'b1100;
  localparam logic [3:0] CTL_DIVU  = 4'b1101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;     // multiply: {partial, multiplier}; divide: {remainder, quotient}
  logic [WIDTH-1:0]     opb_q, opb_d;     // |multiplicand| or |divisor|
  logic                 is_div_q, is_div_d;
  logic                 neg_lo_q, neg_lo_d;  // product / quotient must be negated
  logic                 neg_hi_q, neg_hi_d;  // remainder must be negated
  logic                 dz_q, dz_d;          // divide by zero
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 done_q, done_d;

  // ---------------- single-cycle ALU ----------------
  logic [WIDTH-1:0] sum, diff;
  assign sum  = data_1 + data_2;
  assign diff = data_1 - data_2;

  // Result mux and signed overflow; mul/div and unused encodings give zero.
  always_comb begin
    res = '0;
    ovf = 1'b0;
    unique case (ctl)
      CTL_AND:  res = data_1 & data_2;
      CTL_OR:   res = data_1 | data_2;
      CTL_ADD: begin
        res = sum;
        ovf = (data_1[WIDTH-1] == data_2[WIDTH-1]) && (sum[WIDTH-1] != data_1[WIDTH-1]);
      end
      CTL_XOR:  res = data_1 ^ data_2;
      CTL_NOR:  res = ~(data_1 | data_2);
      CTL_SUB: begin
        res = diff;
        ovf = (data_1[WIDTH-1] != data_2[WIDTH-1]) && (diff[WIDTH-1] != data_1[WIDTH-1]);
      end
      CTL_SLT:  res = {{(WIDTH-1){1'b0}}, ($signed(data_1) < $signed(data_2))};
      CTL_MFHI: res = hi_q;
      CTL_MFLO: res = lo_q;
      default:  res = '0;
    endcase
  end

  assign zero = (res == '0);

  // ---------------- operation decode ----------------
  logic is_md, is_signed, is_div_op, is_hilo_user;
  assign is_md        = (ctl == CTL_MULT) || (ctl == CTL_MULTU) || (ctl == CTL_DIV) || (ctl == CTL_DIVU);
  assign is_signed    = (ctl == CTL_MULT) || (ctl == CTL_DIV);
  assign is_div_op    = (ctl == CTL_DIV)  || (ctl == CTL_DIVU);
  assign is_hilo_user = is_md || (ctl == CTL_MFHI) || (ctl == CTL_MFLO);

  logic             neg_a, neg_b;
  logic [WIDTH-1:0] abs_a, abs_b;
  assign neg_a = is_signed & data_1[WIDTH-1];
  assign neg_b = is_signed & data_2[WIDTH-1];
  assign abs_a = neg_a ? -data_1 : data_1;
  assign abs_b = neg_b ? -data_2 : data_2;

  // ---------------- datapath steps ----------------
  // Shift-add multiply: add multiplicand into the upper half when the
  // multiplier LSB is set, then shift the whole accumulator right (carry kept).
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opb_q : '0)};
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Restoring divide: shift in the next dividend bit with a WIDTH+1 bit
  // partial remainder so divisors with the MSB set still compare correctly.
  logic [WIDTH:0]     rem_sh, rem_sub;
  logic               rem_ge;
  logic [2*WIDTH-1:0] div_next;
  assign rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign rem_ge   = (rem_sh >= {1'b0, opb_q});
  assign rem_sub  = rem_sh - {1'b0, opb_q};
  assign div_next = {(rem_ge ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], rem_ge};

  // Sign correction. A zero divisor leaves the remainder equal to |dividend|,
  // so restoring its sign returns the dividend as captured; LO is forced all ones.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  assign prod_fix = neg_lo_q ? -acc_q : acc_q;
  assign quo_fix  = dz_q ? '1 : (neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
  assign rem_fix  = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  // ---------------- FSM ----------------
  // Next-state and datapath update; flush wins over start and aborts RUN/FIX.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    dz_d     = dz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start && is_md && !flush) begin
          state_d  = S_RUN;
          cnt_d    = CNT_W'(WIDTH);
          is_div_d = is_div_op;
          neg_lo_d = neg_a ^ neg_b;
          neg_hi_d = neg_a;
          dz_d     = is_div_op && (data_2 == '0);
          if (is_div_op) begin
            acc_d = {{WIDTH{1'b0}}, abs_a};
            opb_d = abs_b;
          end else begin
            acc_d = {{WIDTH{1'b0}}, abs_b};
            opb_d = abs_a;
          end
        end
      end
      S_RUN: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          acc_d = is_div_q ? div_next : mul_next;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!flush) begin
          done_d = 1'b1;
          if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      dz_q     <= dz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign stall     = busy & is_hilo_user;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign dbg_state = state_q;

endmodule

// File: doc/alu_mdu.md
Name: alu_mdu

Overview:
- Parametrised successor to the single-cycle datapath ALU.
- Adds NOR, XOR and a signed set-less-than to the logic/arithmetic set, plus signed/unsigned flags (zero, overflow).
- Adds an iterative multiply/divide unit that writes HI/LO registers, with a start/busy/done handshake.
- Sits in the EX stage. The pipeline control uses `stall` to hold the stage while a HI/LO-dependent op waits.

Parameters:
- WIDTH, 32, datapath width in bits (≥4, even).
- CNT_W, $clog2(WIDTH)+1, iteration counter width.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- ctl  input  4  operation select
- data_1  input  WIDTH  operand A / dividend / multiplicand
- data_2  input  WIDTH  operand B / divisor / multiplier
- start  input  1  request to launch MULT/MULTU/DIV/DIVU in ctl
- flush  input  1  synchronous abort of in-flight mul/div
- res  output  WIDTH  combinational result
- zero  output  1  res == 0
- ovf  output  1  signed overflow for ADD/SUB, else 0
- busy  output  1  mul/div in progress
- done  output  1  one-cycle pulse, HI/LO just written
- stall  output  1  busy and ctl is a mul/div/MFHI/MFLO op
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- ctl encoding:
  - AND 0000, OR 0001, ADD 0010, XOR 0011, NOR 0100
  - SUB 0110, SLT 0111 (signed, res = {0…,1} or 0)
  - MFHI 1000, MFLO 1001
  - MULT 1010, MULTU 1011, DIV 1100, DIVU 1101
  - others: res = 0.
- Combinational ops:
  - res is valid in the same cycle.
  - ADD/SUB wrap modulo 2^WIDTH.
  - ovf = operand signs equal (ADD) or differing (SUB), and result sign differs from data_1.
  - MFHI/MFLO return hi/lo. The value is stale while busy; stall flags this.
  - Mul/div ctl values give res = 0.
- Reset (rst_n low, async):
  - hi = lo = 0, busy = 0, done = 0, counter = 0, FSM to IDLE.
  - res, zero and ovf remain combinational functions of their inputs.
- FSM states: IDLE, RUN, FIX.
  - IDLE:
    - start = 1 with a mul/div ctl is accepted at edge E0.
    - Captures absolute values (signed ops) or raw values (unsigned ops), the result signs, op type, and counter = WIDTH.
    - Next state RUN; busy = 1 from E0.
    - start with a non-mul/div ctl is ignored.
  - RUN:
    - One radix-2 step per edge: shift-add multiply, or restoring divide with 2·WIDTH accumulator.
    - Counter decrements each step; after WIDTH steps (edge E_WIDTH) go to FIX.
  - FIX (edge E_WIDTH+1):
    - Apply sign correction. Product is negated if signs differ. Quotient sign = xor of operand signs; remainder sign = dividend sign.
    - Write hi/lo: HI = product[2W-1:W] or remainder; LO = product[W-1:0] or quotient.
    - busy = 0 and done = 1 for exactly the following cycle; return to IDLE.
  - Total latency: accept edge → hi/lo valid = WIDTH+1 edges (33 for WIDTH=32).
- start while busy: ignored; no queuing.
- start on the same edge that done asserts: accepted, since the FSM is in IDLE that cycle.
- Divide by zero: no trap; completes with normal latency. HI = data_1 as captured, LO = all ones, for both DIV and DIVU.
- Most-negative / −1 (signed DIV): LO = most-negative, HI = 0 (wrap).
- flush:
  - Priority over start on the same edge.
  - In RUN/FIX: FSM returns to IDLE, busy = 0, no done; hi/lo unchanged.
  - In IDLE: no effect.
- Reset asserted mid-operation: immediate abort, registers cleared, no done.
- stall = busy & (ctl ∈ {MFHI, MFLO, MULT, MULTU, DIV, DIVU}).

Test Plan:
- WIDTH=32, ADD 7FFFFFFF+00000001 → res 80000000, ovf 1, zero 0. SUB 5−5 → res 0, zero 1, ovf 0. SLT FFFFFFFF,00000001 → res 1.
- MULT FFFFFFFD (−3) × 00000005, start pulse → busy for 33 cycles, done pulse once, hi FFFFFFFF, lo FFFFFFF1. MULTU same operands → hi 00000004, lo FFFFFFF1.
- DIV FFFFFFF9 (−7) / 00000002 → lo FFFFFFFD, hi FFFFFFFF. DIVU 00000064 / 00000007 → lo 0000000E, hi 00000002.
- DIVU 00001234 / 0 → after 33 cycles hi 00001234, lo FFFFFFFF. DIV 80000000 / FFFFFFFF → lo 80000000, hi 0.
- Second start during busy → ignored, result matches first op. ctl=MFLO while busy → stall 1. Back-to-back start on the done cycle → second op accepted.
- flush at cycle 10 of a MULT → busy 0 next cycle, no done, hi/lo keep prior values. rst_n pulled low mid-DIV → hi = lo = 0, busy 0 immediately.
